pc_ctrl: RTL and testbench

//  Fetch-stage controller. Owns the PC, issues requests to instruction memory over a req/ack handshake,
//  and applies redirects (exception > branch) with flush. Resolves per-stage stall requests into a pipeline hold vector.

---
 rtl/pc_ctrl_pkg.sv | 9 +
 rtl/pc_ctrl_if.sv | 9 +
 rtl/pc_ctrl_stall_encoder.sv | 11 +
 rtl/pc_ctrl.sv | 91 +++++++++
 tb/tb_pc_ctrl.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: fetch controller state encodings and default vectors
package pc_ctrl_pkg;
  typedef enum logic [1:0] {S_BOOT, S_ISSUE, S_HOLD, S_DRAIN} state_t;
  localparam logic [31:0] RESET_VECTOR_D = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_D = 32'h0000_0020;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam int STAGES_D = 5;
  localparam int TIMEOUT_D = 255;
endpackage

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: instruction memory req/ack port
interface pc_ctrl_if;
  logic req;
  logic [31:0] addr;
  logic ack;
  logic [31:0] rdata;
  modport master(output req, addr, input ack, rdata);
  modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/pc_ctrl_stall_encoder.sv
// pc_ctrl_stall_encoder: thermometer hold vector from highest stalling stage
module pc_ctrl_stall_encoder #(
  parameter int STAGES = 5
) (
  input  logic [STAGES-1:0] stall_req,
  output logic [STAGES-1:0] hold
);
  for (genvar i = 0; i < STAGES; i++) begin : g_hold
    assign hold[i] = |stall_req[STAGES-1:i];
  end
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage PC owner, imem handshake, redirect/drain and stall hold
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_D,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_D,
  parameter int STAGES = STAGES_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              exc_req,
  pc_ctrl_if.master         imem,
  output logic              ce,
  output logic [31:0]       pc_addr,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [31:0]       if_pc,
  output logic [STAGES-1:0] hold,
  output logic              flush,
  output logic              fetch_err
);
  state_t state, state_n;
  logic [31:0] drain_addr, drain_n, pc_n, inst_n, ipc_n, target;
  logic [7:0] cnt, cnt_n;
  logic valid_n, redirect;
  pc_ctrl_stall_encoder #(.STAGES(STAGES)) u_enc (.stall_req(stall_req), .hold(hold));
  assign redirect = exc_req | branch_taken;
  assign target = exc_req ? EXC_VECTOR : {branch_target[31:2], 2'b00};
  assign imem.req = (state == S_ISSUE && !hold[0]) || state == S_DRAIN;
  assign imem.addr = state == S_DRAIN ? drain_addr : pc_addr;
  assign cnt_n = (imem.ack || redirect) ? 8'd0 : (imem.req && cnt != 8'(TIMEOUT)) ? cnt + 8'd1 : cnt;
  always_comb begin
    state_n = state;
    pc_n = pc_addr;
    valid_n = if_valid;
    inst_n = if_inst;
    ipc_n = if_pc;
    drain_n = drain_addr;
    case (state)
      S_BOOT: state_n = S_ISSUE;
      S_ISSUE: begin
        valid_n = imem.ack;
        if (imem.ack) begin
          inst_n = imem.rdata;
          ipc_n = pc_addr;
          pc_n = pc_addr + 32'd4;
          state_n = hold[0] ? S_HOLD : S_ISSUE;
        end
      end
      S_HOLD: state_n = hold[0] ? S_HOLD : S_ISSUE;
      default: state_n = imem.ack ? S_ISSUE : S_DRAIN;
    endcase
    // a redirect discards any data landing this cycle; an unacked fetch must still drain
    if (redirect) begin
      pc_n = target;
      valid_n = 1'b0;
      inst_n = if_inst;
      ipc_n = if_pc;
      drain_n = imem.addr;
      state_n = (imem.req && !imem.ack) ? S_DRAIN : S_ISSUE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_BOOT;
      ce <= 1'b0;
      pc_addr <= RESET_VECTOR;
      drain_addr <= RESET_VECTOR;
      if_valid <= 1'b0;
      if_inst <= ZERO_WORD;
      if_pc <= ZERO_WORD;
      flush <= 1'b0;
      fetch_err <= 1'b0;
      cnt <= 8'd0;
    end else begin
      state <= state_n;
      ce <= 1'b1;
      pc_addr <= pc_n;
      drain_addr <= drain_n;
      if_valid <= valid_n;
      if_inst <= inst_n;
      if_pc <= ipc_n;
      flush <= redirect;
      fetch_err <= fetch_err | (cnt == 8'(TIMEOUT));
      cnt <= cnt_n;
    end
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed and randomized checks of pc_ctrl against a behavioural fetch model
module tb_pc_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] stall_req = '0;
  logic branch_taken = 1'b0, exc_req = 1'b0;
  logic [31:0] branch_target = '0;
  logic ce, if_valid, flush, fetch_err;
  logic [31:0] pc_addr, if_inst, if_pc;
  logic [4:0] hold;
  int n_chk = 0, n_err = 0;
  pc_ctrl_if imem();
  pc_ctrl dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken(branch_taken),
    .branch_target(branch_target), .exc_req(exc_req), .imem(imem), .ce(ce),
    .pc_addr(pc_addr), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .hold(hold), .flush(flush), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  bit m_live, m_drain, m_held, m_valid, m_flush, m_err, m_ce;
  logic [31:0] m_pc, m_daddr, m_inst, m_ipc;
  int m_wait;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [4:0] m_hold(input logic [4:0] s);
    int hi = -1;
    for (int i = 0; i < 5; i++) if (s[i]) hi = i;
    return 5'((1 << (hi + 1)) - 1);
  endfunction
  function automatic bit m_req(input logic [4:0] s);
    logic [4:0] h = m_hold(s);
    return m_drain || (m_live && !m_held && !h[0]);
  endfunction
  task automatic model_reset();
    {m_live, m_drain, m_held, m_valid, m_flush, m_err, m_ce} = '0;
    m_pc = 32'h0; m_daddr = 32'h0; m_inst = 32'h0; m_ipc = 32'h0; m_wait = 0;
  endtask
  task automatic step(input logic [4:0] s, input bit br, input logic [31:0] bt, input bit ex,
                      input bit ack, input logic [31:0] rd);
    logic [4:0] h;
    logic [31:0] addr, tgt;
    bit req, redir;
    stall_req = s; branch_taken = br; branch_target = bt; exc_req = ex;
    imem.ack = ack; imem.rdata = rd;
    h = m_hold(s);
    req = m_req(s);
    addr = m_drain ? m_daddr : m_pc;
    redir = br | ex;
    tgt = ex ? 32'h20 : {bt[31:2], 2'b00};
    #1;
    check("hold", hold, h);
    check("req", imem.req, req);
    check("addr", imem.addr, addr);
    @(posedge clk);
    m_err = m_err | (m_wait == 255);
    m_wait = (ack || redir) ? 0 : req ? (m_wait == 255 ? 255 : m_wait + 1) : m_wait;
    m_flush = redir;
    if (redir) begin
      if (req && !ack) begin m_daddr = addr; m_drain = 1; end else m_drain = 0;
      m_held = 0; m_valid = 0; m_pc = tgt; m_live = 1;
    end else if (!m_live) m_live = 1;
    else if (m_drain) begin if (ack) m_drain = 0; end
    else if (m_held) m_held = h[0];
    else if (ack) begin
      m_valid = 1; m_inst = rd; m_ipc = m_pc; m_pc = m_pc + 32'd4; m_held = h[0];
    end else m_valid = 0;
    m_ce = m_live;
    #1;
    check("pc_addr", pc_addr, m_pc);
    check("if_valid", if_valid, m_valid);
    check("if_inst", if_inst, m_inst);
    check("if_pc", if_pc, m_ipc);
    check("flush", flush, m_flush);
    check("fetch_err", fetch_err, m_err);
    check("ce", ce, m_ce);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_ce", ce, 0);
    check("rst_pc", pc_addr, 32'h0);
    check("rst_addr", imem.addr, 32'h0);
    check("rst_req", imem.req, 0);
    check("rst_valid", if_valid, 0);
    check("rst_inst", if_inst, 0);
    check("rst_ifpc", if_pc, 0);
    check("rst_flush", flush, 0);
    check("rst_err", fetch_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    imem.ack = 1'b0;
    imem.rdata = '0;
    @(negedge clk);
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    check("boot_ce", ce, 1);
    step(0, 0, 0, 0, 1, 32'hA0);
    check("first_ifpc", if_pc, 32'h0);
    check("first_inst", if_inst, 32'hA0);
    step(0, 0, 0, 0, 1, 32'hA4);
    check("second_ifpc", if_pc, 32'h4);
    check("next_addr", imem.addr, 32'h8);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h103, 0, 0, 0);
    check("drain_flush", flush, 1);
    check("drain_pc", pc_addr, 32'h100);
    step(0, 0, 0, 0, 0, 0);
    check("flush_once", flush, 0);
    step(0, 0, 0, 0, 1, 32'hDEAD);
    check("stale_drop", if_valid, 0);
    check("post_drain_addr", imem.addr, 32'h100);
    step(0, 0, 0, 0, 1, 32'h1234);
    check("target_ifpc", if_pc, 32'h100);
    step(0, 1, 32'h200, 1, 1, 32'h5555);
    check("exc_pc", pc_addr, 32'h20);
    check("exc_flush", flush, 1);
    step(0, 0, 0, 0, 0, 0);
    check("exc_flush_once", flush, 0);
    step(5'b00100, 0, 0, 0, 0, 0);
    check("hold_therm", hold, 5'b00111);
    step(5'b00100, 0, 0, 0, 1, 32'hCAFE);
    check("hold_inst", if_inst, 32'hCAFE);
    for (int i = 0; i < 3; i++) step(5'b00100, 0, 0, 0, 0, 0);
    check("hold_noreq", imem.req, 0);
    check("hold_frozen", if_inst, 32'hCAFE);
    step(0, 0, 0, 0, 0, 0);
    check("release_req", imem.req, 1);
    for (int i = 0; i < 256; i++) step(0, 0, 0, 0, 0, 0);
    check("timeout_err", fetch_err, 1);
    step(0, 0, 0, 0, 1, 32'h77);
    check("err_sticky", fetch_err, 1);
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("req_pending", imem.req, 1);
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    check("no_valid_after_rst", if_valid, 0);
    for (int i = 0; i < 600; i++) begin
      logic [4:0] s;
      bit br, ex, ack;
      s = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      br = $urandom_range(0, 15) == 0;
      ex = $urandom_range(0, 31) == 0;
      ack = m_req(s) && $urandom_range(0, 1) == 1;
      step(s, br, $urandom, ex, ack, $urandom);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
